cmp_selftest: RTL and testbench
===============================

CMP_SELFTEST -- requirements
Module: cmp_selftest

Interface
REQ-001 The block SHALL provide parameter SETTLE_CYCLES, default 2, giving the cycles each vector is held before sampling (legal range 1..15).
REQ-002 clk  input  1  Single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  Reset, asynchronous and active-low.
REQ-004 start  input  1  Pulse that begins an exhaustive run; level-sampled.
REQ-005 A  output  4  Operand A driven to comparator_4bit.
REQ-006 B  output  4  Operand B driven to comparator_4bit.
REQ-007 eq  input  1  Equality result returned by comparator_4bit.
REQ-008 gt  input  1  Greater-than result (A>B) returned by comparator_4bit.
REQ-009 lt  input  1  Less-than result (A<B) returned by comparator_4bit.
REQ-010 busy  output  1  High while a run is in progress.
REQ-011 done  output  1  High from run completion until the next start or reset.
REQ-012 pass  output  1  Valid while done is high; 1 iff err_count == 0.
REQ-013 err_count  output  9  Number of failing vectors in the current or last run (0..256).
REQ-014 fail_valid  output  1  High once the first failing vector has been captured.
REQ-015 fail_a, fail_b  output  4 each  Operands of the first failing vector.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, CHECK and DONE, encoded as an enumerated type.
REQ-017 IDLE/DONE with start=1: next cycle enters SETTLE with A=0, B=0, err_count=0, fail_valid=0, fail_a/fail_b=0, busy=1, done=0.
REQ-018 start SHALL be ignored while busy=1.
REQ-019 SETTLE SHALL hold A/B for exactly SETTLE_CYCLES cycles, then go to CHECK.
REQ-020 CHECK SHALL compare {eq,gt,lt} against a golden value: 100 if A==B, 010 if A>B, 001 if A<B (unsigned).
REQ-021 Any mismatch, including non-one-hot results, SHALL increment err_count by 1 in the CHECK cycle.
REQ-022 On the first mismatch of a run the block SHALL latch fail_a=A and fail_b=B and set fail_valid; later mismatches SHALL not overwrite them.
REQ-023 After CHECK, if {A,B}==8'hFF the FSM SHALL go to DONE; otherwise it SHALL increment {A,B} as one 8-bit counter (B is the LSB nibble) and return to SETTLE.
REQ-024 Vector order SHALL be (0,0),(0,1)..(0,F),(1,0)..(F,F), 256 vectors with no repeats or skips.
REQ-025 DONE SHALL assert done=1 and busy=0, with pass=(err_count==0), and hold all results until start or reset.
REQ-026 done SHALL first be high exactly 256*(SETTLE_CYCLES+1)+1 cycles after the edge that samples start.
REQ-027 In IDLE, A and B SHALL be 0, and pass SHALL be 0.

Reset
REQ-028 rst_n low SHALL immediately force state=IDLE and set A, B, busy, done, pass, err_count, fail_valid, fail_a and fail_b to 0, including mid-run.
REQ-029 After rst_n deassertion, the block SHALL stay in IDLE until a start is sampled; no run resumes.

Structure
REQ-030 A shared package cmp_selftest_pkg SHALL hold the state enum, the 4-bit operand width constant, the 9-bit count width and the one-hot result encodings (EQ/GT/LT).
REQ-031 The golden model SHALL be a separate combinational sub-module, cmp_ref_model (inputs A, B; outputs exp_eq, exp_gt, exp_lt), instantiated once.
REQ-032 The bench SHALL instantiate cmp_selftest wired to comparator_4bit; fault cases use a fault-injecting wrapper around it.

Verification
REQ-033 Good comparator, SETTLE_CYCLES=2, start pulse -> done after 769 cycles, pass=1, err_count=0, fail_valid=0.
REQ-034 gt forced to 0 -> err_count=120, fail_valid=1, fail_a=1, fail_b=0, pass=0.
REQ-035 eq forced to 1 -> err_count=240, fail_a=0, fail_b=1.
REQ-036 SETTLE_CYCLES=1, good comparator -> done after 513 cycles, pass=1.
REQ-037 start re-pulsed at cycle 100 of a run -> ignored; done still at cycle 769.
REQ-038 rst_n pulsed low at cycle 300 -> all outputs 0 asynchronously, state IDLE; a new start gives a full clean run with done 769 cycles later.

Source files
------------

// File: rtl/cmp_selftest_pkg.sv
// Shared types and constants for the 4-bit comparator self-test block.
// Holds the FSM state enum, the data widths and the one-hot result codes.
package cmp_selftest_pkg;

  localparam int OP_W  = 4;
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  // Result codes are ordered {eq, gt, lt}
  typedef logic [2:0] res_t;
  localparam res_t RES_EQ = 3'b100;
  localparam res_t RES_GT = 3'b010;
  localparam res_t RES_LT = 3'b001;

endpackage

// File: rtl/cmp_ref_model.sv
// Golden model of an unsigned 4-bit comparator.
// Produces exactly one asserted result for every operand pair.
module cmp_ref_model
  import cmp_selftest_pkg::*;
(
  input  logic [OP_W-1:0] A,
  input  logic [OP_W-1:0] B,
  output logic            exp_eq,
  output logic            exp_gt,
  output logic            exp_lt
);

  res_t res;

  always_comb begin
    if (A == B)     res = RES_EQ;
    else if (A > B) res = RES_GT;
    else            res = RES_LT;
  end

  assign {exp_eq, exp_gt, exp_lt} = res;

endmodule

// File: rtl/cmp_selftest.sv
// Exhaustive self-test sequencer for an external 4-bit comparator.
// Walks all 256 operand pairs, counts mismatches, and captures the first failing pair.
module cmp_selftest
  import cmp_selftest_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [OP_W-1:0]  A,
  output logic [OP_W-1:0]  B,
  input  logic             eq,
  input  logic             gt,
  input  logic             lt,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic             fail_valid,
  output logic [OP_W-1:0]  fail_a,
  output logic [OP_W-1:0]  fail_b
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic [2*OP_W-1:0]   vec;
  logic [3:0]          settle_cnt;
  logic                done_r;
  logic                exp_eq;
  logic                exp_gt;
  logic                exp_lt;
  logic                mismatch;
  logic                last_vec;
  logic                launch;

  cmp_ref_model u_ref (
    .A      (A),
    .B      (B),
    .exp_eq (exp_eq),
    .exp_gt (exp_gt),
    .exp_lt (exp_lt)
  );

  // B is the low nibble, so the walk is (0,0),(0,1)..(F,F)
  assign A        = vec[2*OP_W-1:OP_W];
  assign B        = vec[OP_W-1:0];
  assign mismatch = ({eq, gt, lt} != {exp_eq, exp_gt, exp_lt});
  assign last_vec = (vec == 8'hFF);
  assign launch   = (state_next == SETTLE) && (state == IDLE || state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through this block can infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) state_next = CHECK;
      CHECK:   state_next = last_vec ? DONE : SETTLE;
      // The first DONE cycle still reports busy, so start is honoured only once done is up
      DONE:    if (start && done_r) state_next = SETTLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SETTLE) || (state == CHECK) || (state == DONE && !done_r);
    done = done_r;
    pass = done_r && (err_count == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec        <= '0;
      settle_cnt <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= (state == DONE) && (state_next == DONE);
      if (launch) begin
        vec        <= '0;
        settle_cnt <= '0;
        err_count  <= '0;
        fail_valid <= 1'b0;
        fail_a     <= '0;
        fail_b     <= '0;
      end else if (state == SETTLE) begin
        settle_cnt <= settle_cnt + 4'd1;
      end else if (state == CHECK) begin
        if (mismatch) begin
          err_count <= err_count + 9'd1;
          if (!fail_valid) begin
            fail_valid <= 1'b1;
            fail_a     <= A;
            fail_b     <= B;
          end
        end
        settle_cnt <= '0;
        if (!last_vec) vec <= vec + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_selftest.sv
// Self-checking bench: two self-test instances (SETTLE_CYCLES 2 and 1), each driving a
// behavioural comparator with a selectable stuck fault; table-driven runs plus a mid-run reset.
module tb_cmp_selftest;
  import cmp_selftest_pkg::*;

  typedef struct {
    int sel;       // 0: SETTLE_CYCLES=2 instance, 1: SETTLE_CYCLES=1 instance
    int fault;     // 0: good, 1: gt stuck at 0, 2: eq stuck at 1
    bit restart;   // re-pulse start at cycle 100
    int exp_cyc;
    int exp_err;
    bit exp_fv;
    int exp_fa;
    int exp_fb;
    bit exp_pass;
  } run_t;

  logic clk;
  logic rst_n;
  logic start_drv;
  int   sel;
  int   fault;
  int   passed;
  int   total;

  logic       start0, start1;
  logic [3:0] a0, b0, a1, b1, fa0, fb0, fa1, fb1;
  logic       eq0, gt0, lt0, eq1, gt1, lt1;
  logic       busy0, done0, pass0, fv0, busy1, done1, pass1, fv1;
  logic [8:0] err0, err1;

  assign start0 = start_drv && (sel == 0);
  assign start1 = start_drv && (sel == 1);

  always_comb begin
    eq0 = (a0 == b0); gt0 = (a0 > b0); lt0 = (a0 < b0);
    if (fault == 1) gt0 = 1'b0;
    if (fault == 2) eq0 = 1'b1;
  end

  always_comb begin
    eq1 = (a1 == b1); gt1 = (a1 > b1); lt1 = (a1 < b1);
    if (fault == 1) gt1 = 1'b0;
    if (fault == 2) eq1 = 1'b1;
  end

  cmp_selftest #(.SETTLE_CYCLES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .A(a0), .B(b0),
    .eq(eq0), .gt(gt0), .lt(lt0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_valid(fv0), .fail_a(fa0), .fail_b(fb0)
  );

  cmp_selftest #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1),
    .eq(eq1), .gt(gt1), .lt(lt1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  logic [3:0] m_a, m_b, m_fa, m_fb;
  logic       m_busy, m_done, m_pass, m_fv;
  logic [8:0] m_err;

  always_comb begin
    m_a = sel ? a1 : a0;       m_b = sel ? b1 : b0;
    m_fa = sel ? fa1 : fa0;    m_fb = sel ? fb1 : fb0;
    m_busy = sel ? busy1 : busy0;
    m_done = sel ? done1 : done0;
    m_pass = sel ? pass1 : pass0;
    m_fv = sel ? fv1 : fv0;
    m_err = sel ? err1 : err0;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic run_one(input run_t v);
    int         n;
    int         steps;
    int         order_bad;
    logic [7:0] prev;
    n = 0; steps = 0; order_bad = 0; prev = 8'h00;
    sel = v.sel;
    fault = v.fault;
    @(negedge clk) start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    while (!m_done && n < 5000) begin
      @(posedge clk);
      n++;
      #1;
      if (n == 1) begin
        check("launch_busy", int'(m_busy), 1);
        check("launch_done", int'(m_done), 0);
        check("launch_err", int'(m_err), 0);
        check("launch_fv", int'(m_fv), 0);
      end
      if (v.restart && n == 100) start_drv = 1'b1;
      if (n == 101) start_drv = 1'b0;
      if ({m_a, m_b} != prev) begin
        if ({m_a, m_b} != prev + 8'd1) order_bad++;
        steps++;
        prev = {m_a, m_b};
      end
    end
    check("done_cycle", n, v.exp_cyc);
    check("err_count", int'(m_err), v.exp_err);
    check("pass", int'(m_pass), int'(v.exp_pass));
    check("fail_valid", int'(m_fv), int'(v.exp_fv));
    check("fail_a", int'(m_fa), v.exp_fa);
    check("fail_b", int'(m_fb), v.exp_fb);
    check("busy_at_done", int'(m_busy), 0);
    check("vector_walk", (order_bad == 0 && steps == 255) ? 1 : 0, 1);
    // Results must hold while in DONE without a new start
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", int'(m_done), 1);
    check("hold_err", int'(m_err), v.exp_err);
  endtask

  run_t tbl[5];

  initial begin
    passed = 0; total = 0;
    rst_n = 1'b0; start_drv = 1'b0; sel = 0; fault = 0;

    tbl[0] = '{sel: 0, fault: 0, restart: 1'b0, exp_cyc: 769, exp_err: 0,
               exp_fv: 1'b0, exp_fa: 0, exp_fb: 0, exp_pass: 1'b1};
    tbl[1] = '{sel: 0, fault: 1, restart: 1'b0, exp_cyc: 769, exp_err: 120,
               exp_fv: 1'b1, exp_fa: 1, exp_fb: 0, exp_pass: 1'b0};
    tbl[2] = '{sel: 0, fault: 2, restart: 1'b0, exp_cyc: 769, exp_err: 240,
               exp_fv: 1'b1, exp_fa: 0, exp_fb: 1, exp_pass: 1'b0};
    tbl[3] = '{sel: 1, fault: 0, restart: 1'b0, exp_cyc: 513, exp_err: 0,
               exp_fv: 1'b0, exp_fa: 0, exp_fb: 0, exp_pass: 1'b1};
    tbl[4] = '{sel: 0, fault: 0, restart: 1'b1, exp_cyc: 769, exp_err: 0,
               exp_fv: 1'b0, exp_fa: 0, exp_fb: 0, exp_pass: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    check("rst_state", int'(u_dut.state), int'(IDLE));
    check("rst_busy", int'(busy0), 0);
    check("rst_done", int'(done0), 0);
    check("rst_pass", int'(pass0), 0);
    check("rst_ab", int'({a0, b0}), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_start", int'(busy0), 0);
    check("idle_pass", int'(pass0), 0);

    for (int i = 0; i < 5; i++) run_one(tbl[i]);

    // Mid-run asynchronous reset at cycle 300 of a faulty run
    sel = 0;
    fault = 1;
    @(negedge clk) start_drv = 1'b1;
    @(posedge clk);
    #1 start_drv = 1'b0;
    repeat (300) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    check("midrst_state", int'(u_dut.state), int'(IDLE));
    check("midrst_ab", int'({a0, b0}), 0);
    check("midrst_busy", int'(busy0), 0);
    check("midrst_done", int'(done0), 0);
    check("midrst_pass", int'(pass0), 0);
    check("midrst_err", int'(err0), 0);
    check("midrst_fail", int'({fv0, fa0, fb0}), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("no_resume_busy", int'(busy0), 0);
    check("no_resume_state", int'(u_dut.state), int'(IDLE));
    run_one(tbl[0]);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
